// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging NUM_MASTERS core access/ack buses onto a single memory port.
// Define MEM_ARBITER_LOCK_EN to add m_lock and the LOCKED state for locked read-modify-write.
module mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 19
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*16-1:0]         m_data_in,
    output logic [15:0]                       m_data_out,
    input  logic [NUM_MASTERS-1:0]            m_access,
    input  logic [NUM_MASTERS-1:0]            m_wr_en,
    input  logic [NUM_MASTERS*2-1:0]          m_bytesel,
`ifdef MEM_ARBITER_LOCK_EN
    input  logic [NUM_MASTERS-1:0]            m_lock,
`endif
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [ADDR_WIDTH:1]               s_addr,
    output logic [15:0]                       s_data_out,
    input  logic [15:0]                       s_data_in,
    output logic                              s_access,
    input  logic                              s_ack,
    output logic                              s_wr_en,
    output logic [1:0]                        s_bytesel,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic [1:0]                        state_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // Debug encoding on state_o: IDLE=0, BUSY=1, RELEASE=2, LOCKED=3.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
`ifdef MEM_ARBITER_LOCK_EN
        , ST_LOCKED = 2'd3
`endif
    } state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IW-1:0]          last_q;
    logic                   s_access_q;

    logic                   win_hit;
    logic [IW-1:0]          win_idx;
    logic [IW-1:0]          scan_idx;
    logic                   own_access;
`ifdef MEM_ARBITER_LOCK_EN
    logic                   own_lock;
    assign own_lock = |(m_lock & grant_q);
`endif

    assign own_access = |(m_access & grant_q);

    // Scan upward from the master after the last winner, wrapping around.
    always_comb begin
        win_hit  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            scan_idx = IW'((int'(last_q) + k) % NUM_MASTERS);
            if (!win_hit && m_access[scan_idx]) begin
                win_hit = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // Handshake: a master holds m_access and its request fields stable until it
    // sees its single-cycle m_ack; s_access/s_ack behave the same on the memory side.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= IW'(NUM_MASTERS - 1);
            s_access_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_hit) begin
                        grant_q    <= NUM_MASTERS'(1) << win_idx;
                        last_q     <= win_idx;
                        s_access_q <= 1'b1;
                        state_q    <= ST_BUSY;
                    end else begin
                        grant_q    <= '0;
                    end
                end
                ST_BUSY: begin
                    if (s_ack) begin
                        s_access_q <= 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
                        state_q    <= own_lock ? ST_LOCKED : ST_RELEASE;
`else
                        state_q    <= ST_RELEASE;
`endif
                    end
                end
                ST_RELEASE: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
`ifdef MEM_ARBITER_LOCK_EN
                // Owner keeps the bus; last_q is left alone so fairness resumes afterwards.
                ST_LOCKED: begin
                    if (own_access) begin
                        s_access_q <= 1'b1;
                        state_q    <= ST_BUSY;
                    end else if (!own_lock) begin
                        grant_q    <= '0;
                        state_q    <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    grant_q    <= '0;
                    s_access_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    // Request fields follow the owner; with no owner the port reads all zeros.
    always_comb begin
        s_addr     = '0;
        s_data_out = '0;
        s_wr_en    = 1'b0;
        s_bytesel  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                s_addr     = s_addr | m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_data_out = s_data_out | m_data_in[i*16 +: 16];
                s_wr_en    = s_wr_en | m_wr_en[i];
                s_bytesel  = s_bytesel | m_bytesel[i*2 +: 2];
            end
        end
    end

    assign m_ack      = (state_q == ST_BUSY && reset) ? (grant_q & {NUM_MASTERS{s_ack}}) : '0;
    assign m_data_out = s_data_in;
    assign s_access   = s_access_q;
    assign grant      = grant_q;
    assign state_o    = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Parametrised N-master arbiter that merges several core-side memory buses onto one memory port.
- Masters are instruction prefetch, load/store, and future DMA or debug ports; all use the core's access/ack handshake.
- Arbitration is round-robin. The grant is held for a whole transaction.
- Optional bus locking keeps the grant across consecutive transactions, for x86 LOCK-prefixed read-modify-write.
- Sits between the core's `instr_m_*`/`data_m_*` buses and the external memory interface.

## Interface
- `NUM_MASTERS`, default 2: number of master ports, 2..8.
- `ADDR_WIDTH`, default 19: word address width; addresses are `[ADDR_WIDTH:1]`.
- `clk` input 1: clock.
- `reset` input 1: one clock; reset is synchronous and active-low.
- `m_addr` input NUM_MASTERS*ADDR_WIDTH: per-master word address; master i occupies slice i.
- `m_data_in` input NUM_MASTERS*16: per-master write data.
- `m_data_out` output 16: read data, broadcast to all masters.
- `m_access` input NUM_MASTERS: per-master request.
- `m_wr_en` input NUM_MASTERS: per-master write enable.
- `m_bytesel` input NUM_MASTERS*2: per-master byte lanes.
- `m_lock` input NUM_MASTERS: per-master lock request. Present only with `MEM_ARBITER_LOCK_EN`.
- `m_ack` output NUM_MASTERS: per-master one-hot acknowledge.
- `s_addr` output ADDR_WIDTH: memory-port word address.
- `s_data_out` output 16: memory-port write data.
- `s_data_in` input 16: memory-port read data.
- `s_access` output 1: memory-port request.
- `s_ack` input 1: memory-port acknowledge.
- `s_wr_en` output 1: memory-port write enable.
- `s_bytesel` output 2: memory-port byte lanes.
- `grant` output NUM_MASTERS: one-hot current owner, 0 when idle. For debug and performance counters.

## Operation
- **States:** IDLE, BUSY, RELEASE, plus LOCKED when the lock feature is compiled in.
- **IDLE**
  - If any `m_access` bit is set, the winner is the first requester found scanning upward from `last+1`, wrapping modulo NUM_MASTERS.
  - The winner is registered into `grant` and `last`; next state is BUSY.
  - No requester: stay in IDLE with `grant`=0.
- **BUSY**
  - `s_addr`, `s_data_out`, `s_wr_en` and `s_bytesel` are a combinational mux from the granted master's slice.
  - `s_access` = 1.
  - `m_ack[g]` = `s_ack`; every other `m_ack` bit is 0.
  - `m_data_out` = `s_data_in` at all times (broadcast); only the acked master samples it.
  - On `s_ack`, next state is RELEASE, or LOCKED when the lock condition below holds.
- **RELEASE**
  - Lasts one cycle. `s_access`=0, `grant` is held, no arbitration.
  - This absorbs the cycle in which the acked master drops `m_access`, so a stale request is never re-granted.
  - Next state is IDLE.
- **Deviations:**
  - A master dropping `m_access` while in BUSY is illegal. The arbiter keeps `s_access` asserted until `s_ack`.
  - `s_ack` in IDLE or RELEASE is ignored and produces no `m_ack`.
- **Reset values:**
  - state = IDLE; `grant`=0; `last`=NUM_MASTERS-1, so master 0 wins first.
  - `s_access`=0, `m_ack`=0.
  - `s_addr`, `s_data_out`, `s_wr_en`, `s_bytesel` = 0 (the mux is forced to 0 when `grant`=0).
- **Reset mid-transaction:** returns to IDLE immediately. Any pending `s_ack` in that cycle is dropped.

## Timing
- `m_access` rises in cycle 0 with the arbiter IDLE:
  - `grant` is valid in cycle 1.
  - `s_access` asserts in cycle 1.
- `s_ack` in cycle k:
  - `m_ack` is asserted in cycle k (zero added latency).
  - RELEASE is cycle k+1.
  - IDLE arbitration is cycle k+2.
  - The next `s_access` is cycle k+3.
- Minimum transaction-to-transaction spacing is 3 cycles without lock.
- **Simultaneous requests:** exactly one grant per arbitration. With every master requesting continuously, each master is served once per NUM_MASTERS transactions.

## Configuration
- **`MEM_ARBITER_LOCK_EN` defined:**
  - `m_lock` exists.
  - If `m_lock[g]` is 1 in the `s_ack` cycle, next state is LOCKED instead of RELEASE.
  - LOCKED holds `grant` with `s_access`=0. It returns to BUSY when `m_access[g]` is asserted, ignoring all other masters.
  - It goes to IDLE when `m_lock[g]` is 0 and `m_access[g]` is 0.
  - `last` is not updated on locked re-entry.
- **`MEM_ARBITER_LOCK_EN` undefined:** no `m_lock` port, no LOCKED state, RELEASE always follows ack.

## Test plan
- **Reset and first grant:** reset low 2 cycles, then masters 0 and 1 request together. Required: `grant`=01, `s_addr`=master 0's address in cycle 1; master 1 is granted after master 0's ack+2.
- **Round-robin fairness:** NUM_MASTERS=4, all requesting continuously, memory acks after 2 cycles, 8 transactions. Required: grant order 0,1,2,3,0,1,2,3.
- **Write path:** master 1 writes 0xBEEF to address 0x12345 with bytesel 10. Required: `s_data_out`=0xBEEF, `s_bytesel`=10, `s_wr_en`=1; only `m_ack[1]` pulses.
- **Stray ack:** `s_ack` pulsed while IDLE. Required: `m_ack`=0, no state change.
- **Reset mid-transaction:** reset asserted in BUSY. Required: next cycle `s_access`=0, `grant`=0, and master 0 has highest priority again.
- **Lock (macro defined):** master 0 performs a locked read then write while master 1 requests throughout. Required: both master 0 transactions complete before master 1 is granted.
